// File: rtl/ysyx_23060077_ifu_fq.sv
// rtl/ysyx_23060077_ifu_fq.sv - fetch unit with multiple outstanding icache reads and an in-order fetch queue
module ysyx_23060077_ifu_fq #(
    parameter int                ADDR_W          = 32,
    parameter logic [ADDR_W-1:0] RESET_PC        = 32'h3000_0000,
    parameter int                INST_W          = 32,
    parameter int                FQ_DEPTH        = 4,
    parameter int                MAX_OUTSTANDING = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              redirect_valid_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    input  logic              fetch_hold_i,
    output logic              icache_req_valid_o,
    output logic [ADDR_W-1:0] icache_req_addr_o,
    input  logic              icache_req_ready_i,
    input  logic              icache_rsp_valid_i,
    input  logic [INST_W-1:0] icache_rsp_data_i,
    output logic              if_to_id_valid_o,
    input  logic              if_to_id_ready_i,
    output logic [ADDR_W-1:0] if_to_id_pc_o,
    output logic [INST_W-1:0] if_to_id_inst_o,
    output logic              icache_fence_o
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int IW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int AW = $clog2(FQ_DEPTH);
    localparam int CW = $clog2(FQ_DEPTH + 1);

    logic [ADDR_W-1:0] r_pc;
    logic [OW-1:0]     r_outstanding;
    logic [OW-1:0]     r_drop_cnt;
    logic [ADDR_W-1:0] r_inf_pc [MAX_OUTSTANDING];
    logic [IW-1:0]     r_inf_wr;
    logic [IW-1:0]     r_inf_rd;
    logic [ADDR_W-1:0] r_fq_pc   [FQ_DEPTH];
    logic [INST_W-1:0] r_fq_inst [FQ_DEPTH];
    logic [AW-1:0]     r_fq_wr;
    logic [AW-1:0]     r_fq_rd;
    logic [CW-1:0]     r_fq_count;

    logic [31:0]       w_used;
    logic              w_acc;
    logic              w_rsp;
    logic              w_drop;
    logic              w_push;
    logic              w_deq;
    logic [OW-1:0]     w_out_next;

    // Slots already promised to in-flight live reads count against the FQ.
    assign w_used = 32'(r_outstanding) - 32'(r_drop_cnt) + 32'(r_fq_count);

    assign icache_req_valid_o = !reset & !fetch_hold_i & !redirect_valid_i
                              & (r_outstanding < OW'(MAX_OUTSTANDING))
                              & (w_used < 32'(FQ_DEPTH));
    assign icache_req_addr_o  = r_pc;

    assign w_acc      = icache_req_valid_o & icache_req_ready_i;
    assign w_rsp      = icache_rsp_valid_i & (r_outstanding != '0);
    assign w_drop     = w_rsp & (r_drop_cnt != '0);
    assign w_push     = w_rsp & !w_drop & !redirect_valid_i;
    assign w_deq      = if_to_id_valid_o & if_to_id_ready_i;
    assign w_out_next = r_outstanding + OW'(w_acc) - OW'(w_rsp);

    assign if_to_id_valid_o = (r_fq_count != '0);
    assign if_to_id_pc_o    = r_fq_pc[r_fq_rd];
    assign if_to_id_inst_o  = r_fq_inst[r_fq_rd];
    assign icache_fence_o   = w_deq & (if_to_id_inst_o[6:0] == 7'b0001111) & if_to_id_inst_o[12];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_outstanding <= w_out_next;
            if (redirect_valid_i) begin
                r_pc       <= redirect_pc_i;
                r_drop_cnt <= w_out_next;
            end else begin
                if (w_acc)
                    r_pc <= r_pc + ADDR_W'(4);
                if (w_drop)
                    r_drop_cnt <= r_drop_cnt - OW'(1);
            end
        end
    end

    // In-flight PC ring: stale entries are popped by their responses, never flushed.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_inf_wr <= '0;
            r_inf_rd <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++)
                r_inf_pc[i] <= '0;
        end else begin
            if (w_acc) begin
                r_inf_pc[r_inf_wr] <= r_pc;
                r_inf_wr <= (r_inf_wr == IW'(MAX_OUTSTANDING - 1)) ? '0 : r_inf_wr + IW'(1);
            end
            if (w_rsp)
                r_inf_rd <= (r_inf_rd == IW'(MAX_OUTSTANDING - 1)) ? '0 : r_inf_rd + IW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_fq_wr    <= '0;
            r_fq_rd    <= '0;
            r_fq_count <= '0;
            for (int i = 0; i < FQ_DEPTH; i++) begin
                r_fq_pc[i]   <= '0;
                r_fq_inst[i] <= '0;
            end
        end else if (redirect_valid_i) begin
            r_fq_wr    <= '0;
            r_fq_rd    <= '0;
            r_fq_count <= '0;
        end else begin
            if (w_push) begin
                r_fq_pc[r_fq_wr]   <= r_inf_pc[r_inf_rd];
                r_fq_inst[r_fq_wr] <= icache_rsp_data_i;
                r_fq_wr            <= r_fq_wr + AW'(1);
            end
            if (w_deq)
                r_fq_rd <= r_fq_rd + AW'(1);
            r_fq_count <= r_fq_count + CW'(w_push) - CW'(w_deq);
        end
    end

endmodule
